ahb_lite_master: RTL

Synthesizable AHB-Lite master (initiator). It accepts single read/write commands from a local command port, queues them, and issues them on the AHB-Lite bus with pipelined address/data phases. It returns one in-order response per command. It is the initiator counterpart to our AHB-Lite slave peripherals (e.g. the FIR filter register file), using the same reduced bus: no HREADY, and one data cycle per transfer.

---
 rtl/ahb_lite_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: queues local read/write commands, issues them as pipelined
// single NONSEQ transfers and returns one in-order response per command.
module ahb_lite_master #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_size,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_write,
    output logic                  busy,
    output logic                  hsel,
    output logic [1:0]            htrans,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hresp
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HALF_W = DATA_WIDTH / 2;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  size;
    } cmd_t;

    cmd_t                  mem_q [FIFO_DEPTH];
    cmd_t                  cmd_in;
    cmd_t                  head;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop, misaligned;

    // Address-phase stage: a_bus marks a real transfer, a_err a local misalignment slot
    logic                  a_valid_q, a_valid_d, a_bus_q, a_bus_d, a_err_q, a_err_d;
    logic                  a_write_q, a_write_d, a_addr0_q, a_addr0_d, a_size_q, a_size_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hsize_q, hsize_d, hwrite_q, hwrite_d;

    logic                  d_valid_q, d_valid_d, d_err_q, d_err_d, d_write_q, d_write_d;
    logic                  d_size_q, d_size_d, d_addr0_q, d_addr0_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;

    logic                  rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic                  rsp_write_q, rsp_write_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    assign cmd_ready  = (count_q != CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign misaligned = head.size && head.addr[0];
    assign cmd_in     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, size: cmd_size};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        a_valid_d   = 1'b0;
        a_bus_d     = 1'b0;
        a_err_d     = 1'b0;
        a_write_d   = a_write_q;
        a_addr0_d   = a_addr0_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        d_valid_d   = a_valid_q;
        d_err_d     = a_err_q;
        d_write_d   = a_write_q;
        d_size_d    = a_size_q;
        d_addr0_d   = a_addr0_q;
        hwdata_d    = '0;
        rsp_valid_d = d_valid_q;
        rsp_error_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_rdata_d = '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            a_valid_d = 1'b1;
            a_bus_d   = !misaligned;
            a_err_d   = misaligned;
            a_write_d = head.write;
            a_addr0_d = head.addr[0];
            a_size_d  = head.size;
            a_wdata_d = head.wdata;
            if (!misaligned) begin
                haddr_d  = head.addr;
                hsize_d  = head.size;
                hwrite_d = head.write;
            end
        end

        // Byte writes replicate the low byte so the slave picks the lane by address
        if (a_bus_q && a_write_q) begin
            hwdata_d = a_size_q ? a_wdata_q : {2{a_wdata_q[HALF_W-1:0]}};
        end

        if (d_valid_q) begin
            rsp_write_d = d_write_q;
            rsp_error_d = d_err_q || hresp;
            if (!d_err_q && !d_write_q) begin
                if (d_size_q) begin
                    rsp_rdata_d = hrdata;
                end else if (d_addr0_q) begin
                    rsp_rdata_d = {{HALF_W{1'b0}}, hrdata[DATA_WIDTH-1:HALF_W]};
                end else begin
                    rsp_rdata_d = {{HALF_W{1'b0}}, hrdata[HALF_W-1:0]};
                end
            end
        end

        busy_d = (count_d != '0) || a_valid_d || d_valid_d || rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            a_valid_q   <= 1'b0;
            a_bus_q     <= 1'b0;
            a_err_q     <= 1'b0;
            a_write_q   <= 1'b0;
            a_addr0_q   <= 1'b0;
            a_size_q    <= 1'b0;
            a_wdata_q   <= '0;
            haddr_q     <= '0;
            hsize_q     <= 1'b0;
            hwrite_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_write_q   <= 1'b0;
            d_size_q    <= 1'b0;
            d_addr0_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            a_valid_q   <= a_valid_d;
            a_bus_q     <= a_bus_d;
            a_err_q     <= a_err_d;
            a_write_q   <= a_write_d;
            a_addr0_q   <= a_addr0_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            d_write_q   <= d_write_d;
            d_size_q    <= d_size_d;
            d_addr0_q   <= d_addr0_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign hsel      = a_bus_q;
    assign htrans    = {a_bus_q, 1'b0};
    assign haddr     = haddr_q;
    assign hsize     = {2'b00, hsize_q};
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign rsp_write = rsp_write_q;
    assign busy      = busy_q;

endmodule
